bcd_down_counter: RTL and testbench
===================================

Name: bcd_down_counter

Overview:
- Synchronous multi-digit BCD (decade) down counter.
- Counterpart of the team's ripple T-flip-flop decade up-counter; counts 9..0 per digit in the opposite direction.
- Used for countdown timers and for cascading with other counters through a borrow chain.
- Fully synchronous: every flop is clocked by clock. There is no ripple clocking between digits.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); counter width is 4*DIGITS bits.

Ports:
- clock  input  1  single clock, posedge.
- reset  input  1  synchronous, active-low reset, sampled on posedge clock.
- en  input  1  count enable; decrement by one when high.
- load  input  1  synchronous parallel load strobe.
- load_val  input  4*DIGITS  BCD load value; digit i is bits [4i+3:4i].
- q  output  4*DIGITS  registered BCD count.
- qb  output  4*DIGITS  registered bitwise complement of q.
- zero  output  1  high when q is all digits 0 (combinational from q).
- borrow_out  output  1  cascade borrow: en & zero & ~load (combinational).

Behaviour:
- Reset:
  - Clock and reset: one clock; reset is synchronous and active-low.
  - reset==0 at posedge: q <= 0 and qb <= all ones.
  - zero==1 follows from q; borrow_out follows its equation.
- Priority at each posedge: reset low > load > en > hold.
- Load: each digit of load_val is registered into q.
  - Any digit value 10..15 is clamped to 9 when loaded.
  - Load ignores en.
- Decrement (en=1, load=0):
  - Digit 0 always steps down.
  - Digit i (i>0) steps down only when digits 0..i-1 are all 0 in the current cycle.
  - A stepping digit at 0 wraps to 9; otherwise it becomes value-1.
- Full-count wrap: q all 0 with en=1 gives q <= all 9s in the next cycle; borrow_out is high during the zero cycle.
- Hold: en=0 and load=0 leaves q unchanged.
- Latency: q updates one clock after the sampled control. zero and borrow_out reflect the current q and inputs in the same cycle.
- qb is always exactly ~q, including after reset and load. It is updated in the same clock edge as q, so it never lags by one cycle.
- q never contains a digit >9 after the first reset. Arithmetic is digit-wise BCD; there is no binary borrow across nibbles.
- Reset mid-operation: reset overrides a concurrent load or en; there is no residual state.

Optional Feature:
- Macro: BCD_DOWN_SATURATE_EN.
- Defined:
  - Counter saturates at 0; en with q==0 leaves q at 0.
  - borrow_out is still asserted (en & zero & ~load) so cascades keep working.
  - Load is unaffected.
- Undefined: wrap to all 9s as described under Behaviour.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_W = 4, BCD_MAX = 4'd9, BCD_ZERO = 4'd0.
  - typedef bcd_digit_t (logic [3:0]).
  - Function bcd_clamp, returning 9 for inputs >9.
- Sub-module bcd_down_digit, one BCD digit:
  - Inputs: clock, reset, load, load_digit, dec_in.
  - Outputs: digit, digit_is_zero.
  - Generated DIGITS times.
  - dec_in for digit i = en & AND of digit_is_zero for digits 0..i-1.
  - The saturate check lives at the top level, gating en when zero.

Test Plan (DIGITS=2):
1. Reset and load: reset=0 for one edge with load=1, load_val=8'h57 -> q=8'h00, qb=8'hFF, zero=1. Then reset=1, load=1, load_val=8'h57 -> q=8'h57, qb=8'hA8.
2. Decrement across a digit boundary: load 8'h11, en=1 for 3 edges -> q sequence 10, 09, 08. Digit 1 decrements only at the 10->09 step.
3. Wrap: load 8'h01, en=1 -> q=00 with zero=1 and borrow_out=1, then q=99 on the next edge. With BCD_DOWN_SATURATE_EN: q stays 00 and borrow_out=1 each cycle.
4. Clamp: load_val=8'hFA -> q=8'h99. load=1 and en=1 with load_val=8'h42 -> q=8'h42 (load wins), borrow_out=0.
5. Hold and priority: en=0, load=0 for 5 edges at q=8'h36 -> q stays 36. reset=0 asserted together with en=1 and load=1 -> q=00.
6. Full sweep: from 99, en=1 for 100 edges -> returns to 99. At every cycle check qb==~q and that each digit is ≤9. zero is high exactly once.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, constants and load clamp helper
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Non-decimal codes 10..15 collapse to 9 so the register never holds an illegal digit.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD decade digit with load, wrap-around decrement and registered complement
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       dec_in,
  output logic [3:0] digit,
  output logic [3:0] digit_b,
  output logic       digit_is_zero
);

  bcd_digit_t next_digit;

  always_comb begin
    next_digit = digit;
    if (load) begin
      next_digit = bcd_clamp(load_digit);
    end else if (dec_in) begin
      next_digit = (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
    end
  end

  // Complement is registered from the same next value so it never lags the count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      digit   <= BCD_ZERO;
      digit_b <= 4'hF;
    end else begin
      digit   <= next_digit;
      digit_b <= ~next_digit;
    end
  end

  assign digit_is_zero = (digit == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// rtl/bcd_down_counter.sv - synchronous multi-digit BCD down counter; BCD_DOWN_SATURATE_EN holds at zero instead of wrapping
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] q,
  output logic [4*DIGITS-1:0] qb,
  output logic                zero,
  output logic                borrow_out
);

  logic [DIGITS-1:0] digit_zero;
  logic              en_eff;

`ifdef BCD_DOWN_SATURATE_EN
  assign en_eff = en & ~zero;
`else
  assign en_eff = en;
`endif

  // A digit steps only when every lower digit is at zero this cycle.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic dec_in;

    if (i == 0) begin : g_lsd
      assign dec_in = en_eff;
    end else begin : g_upper
      assign dec_in = en_eff & (&digit_zero[i-1:0]);
    end

    bcd_down_digit u_digit (
      .clock        (clock),
      .reset        (reset),
      .load         (load),
      .load_digit   (load_val[4*i +: BCD_W]),
      .dec_in       (dec_in),
      .digit        (q[4*i +: BCD_W]),
      .digit_b      (qb[4*i +: BCD_W]),
      .digit_is_zero(digit_zero[i])
    );
  end

  assign zero       = &digit_zero;
  assign borrow_out = en & zero & ~load;

endmodule

// File: tb/tb_bcd_down_counter.sv
// tb/tb_bcd_down_counter.sv - vector table plus scoreboard bench for bcd_down_counter (DIGITS=2)
module tb_bcd_down_counter;

  localparam int DIGITS = 2;
  localparam int W = 4 * DIGITS;

`ifdef BCD_DOWN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         zero;
  logic         borrow_out;

  bcd_down_counter #(.DIGITS(DIGITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .q         (q),
    .qb        (qb),
    .zero      (zero),
    .borrow_out(borrow_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         rst;
    logic         ld;
    logic         inc_en;
    logic [W-1:0] lv;
    logic [W-1:0] exp_q;
    logic         exp_borrow;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference next state computed digit by digit from the bench's own expected count.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input logic rst,
                                              input logic ld, input logic e, input logic [W-1:0] lv);
    logic [W-1:0] n;
    logic         step;
    n = cur;
    if (!rst) return '0;
    if (ld) begin
      for (int d = 0; d < DIGITS; d++)
        n[4*d +: 4] = (lv[4*d +: 4] > 4'd9) ? 4'd9 : lv[4*d +: 4];
      return n;
    end
    if (!e || (SAT && cur == '0)) return cur;
    step = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (step) n[4*d +: 4] = (cur[4*d +: 4] == 4'd0) ? 4'd9 : cur[4*d +: 4] - 4'd1;
      step = step && (cur[4*d +: 4] == 4'd0);
    end
    return n;
  endfunction

  // Drive at negedge, check combinational borrow, push expectation, pop and compare after posedge.
  task automatic apply(input string name, input logic rst, input logic ld, input logic e,
                       input logic [W-1:0] lv, input logic [W-1:0] exp_q, input logic exp_borrow);
    logic [W-1:0] exp;
    @(negedge clock);
    reset = rst; load = ld; en = e; load_val = lv;
    #1;
    check({name, "_borrow"}, W'(borrow_out), W'(exp_borrow));
    sb_q.push_back(exp_q);
    @(posedge clock);
    #1;
    exp = sb_q.pop_front();
    check({name, "_q"}, q, exp);
    check({name, "_qb"}, qb, ~exp);
    check({name, "_zero"}, W'(zero), W'(exp == '0));
  endtask

  vec_t vecs[$];
  logic [W-1:0] model_q;
  int zero_count;
  int digit_bad;

  initial begin
    reset = 1'b0; load = 1'b0; en = 1'b0; load_val = '0;

    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h57, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h57, 8'h57, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h11, 8'h11, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'h10, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'h09, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'h08, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h00, SAT ? 8'h00 : 8'h99, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h00, SAT ? 8'h00 : 8'h98, SAT});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'hFA, 8'h99, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'h42, 8'h42, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h36, 8'h36, 1'b0});
    for (int k = 0; k < 5; k++)
      vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h36, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h77, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'h42, 8'h42, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'hBC, 8'h99, 1'b0});

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].ld, vecs[i].inc_en,
            vecs[i].lv, vecs[i].exp_q, vecs[i].exp_borrow);

    // Full sweep from 99: 100 decrements, tracked against the reference model.
    model_q = 8'h99;
    zero_count = 0;
    digit_bad = 0;
    for (int c = 0; c < 100; c++) begin
      model_q = model_next(model_q, 1'b1, 1'b0, 1'b1, '0);
      apply($sformatf("sweep%0d", c), 1'b1, 1'b0, 1'b1, 8'h00, model_q,
            (c > 0 && SAT && model_q == '0) ? 1'b1 : (model_q == 8'h99 && !SAT) ? 1'b1 : 1'b0);
      if (zero) zero_count++;
      for (int d = 0; d < DIGITS; d++)
        if (q[4*d +: 4] > 4'd9) digit_bad++;
    end
    check("sweep_end_q", q, SAT ? 8'h00 : 8'h99);
    check("sweep_zero_count", W'(zero_count), SAT ? W'(2) : W'(1));
    check("sweep_digit_range", W'(digit_bad), W'(0));

    @(negedge clock);
    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
